tx_xgmii_framer: RTL and testbench

- Consumes 64-bit data words plus an 8-bit status byte from the TX hold FIFO, which sits directly upstream.
- Produces XGMII TX lanes (txd/txc): start/preamble word, payload, terminate, and inter-frame idles.
- The CRC is already present in the payload. This block only frames and encodes.
- Handles FIFO underrun mid-frame by emitting error code words and then discarding the remainder of the frame.

---
 rtl/xgmii_pkg.sv | 39 +++
 rtl/tx_xgmii_term_encode.sv | 29 ++
 rtl/tx_xgmii_framer.sv | 173 +++++++++++++++++
 tb/tb_tx_xgmii_framer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII TX constants, status-byte layout, framer state and word payload.
package xgmii_pkg;

    localparam int unsigned XGMII_DATA_W = 64;
    localparam int unsigned XGMII_CTRL_W = 8;
    localparam int unsigned XGMII_LANES  = 8;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] PREAMBLE    = 8'h55;
    localparam logic [7:0] SFD         = 8'hD5;

    localparam int unsigned TXSTATUS_SOP         = 7;
    localparam int unsigned TXSTATUS_EOP         = 6;
    localparam int unsigned TXSTATUS_NBYTES_MSB  = 2;
    localparam int unsigned TXSTATUS_NBYTES_LSB  = 0;

    localparam logic [XGMII_DATA_W-1:0] IDLE_WORD  = {XGMII_LANES{XGMII_IDLE}};
    localparam logic [XGMII_DATA_W-1:0] START_WORD = {SFD, {6{PREAMBLE}}, XGMII_START};
    localparam logic [XGMII_DATA_W-1:0] ERROR_WORD = {XGMII_LANES{XGMII_ERROR}};
    localparam logic [XGMII_DATA_W-1:0] TERM_WORD  = {{7{XGMII_IDLE}}, XGMII_TERM};

    // One XGMII transfer: eight lanes of data plus their control flags.
    typedef struct packed {
        logic [XGMII_DATA_W-1:0] txd;
        logic [XGMII_CTRL_W-1:0] txc;
    } xgmii_word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_TERM  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_IFG   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/tx_xgmii_term_encode.sv
// Builds the mixed data/terminate word for a final word carrying 1..7 valid bytes.
module tx_xgmii_term_encode
    import xgmii_pkg::*;
(
    input  logic [XGMII_DATA_W-1:0] data_i,
    input  logic [2:0]              nbytes_i,
    output logic [XGMII_DATA_W-1:0] txd_o,
    output logic [XGMII_CTRL_W-1:0] txc_o
);

    // Lanes below n carry data, lane n terminates, lanes above n idle.
    always_comb begin
        txd_o = IDLE_WORD;
        txc_o = '1;
        for (int unsigned k = 0; k < XGMII_LANES; k++) begin
            if (k < 32'(nbytes_i)) begin
                txd_o[8*k +: 8] = data_i[8*k +: 8];
                txc_o[k]        = 1'b0;
            end else if (k == 32'(nbytes_i)) begin
                txd_o[8*k +: 8] = XGMII_TERM;
                txc_o[k]        = 1'b1;
            end else begin
                txd_o[8*k +: 8] = XGMII_IDLE;
                txc_o[k]        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_xgmii_framer.sv
// Frames TX hold-FIFO words onto XGMII: start, payload, terminate, IFG idles,
// with error-word insertion and frame discard on mid-frame underrun.
module tx_xgmii_framer
    import xgmii_pkg::*;
#(
    parameter int unsigned IFG_WORDS  = 2,
    parameter int unsigned START_WAIT = 16
) (
    input  logic                    clk_xgmii_tx,
    input  logic                    reset_xgmii_tx,
    input  logic [XGMII_DATA_W-1:0] txhfifo_rdata,
    input  logic [7:0]              txhfifo_rstatus,
    input  logic                    txhfifo_rempty,
    input  logic                    txhfifo_ralmost_empty,
    output logic                    txhfifo_ren,
    output logic [XGMII_DATA_W-1:0] xgmii_txd,
    output logic [XGMII_CTRL_W-1:0] xgmii_txc,
    output logic                    tx_underrun,
    output logic                    tx_frame_done
);

    localparam int unsigned WAIT_W = 8;
    localparam int unsigned IFG_W  = 4;

    localparam xgmii_word_t IDLE_XFER  = '{txd: IDLE_WORD,  txc: 8'hFF};
    localparam xgmii_word_t START_XFER = '{txd: START_WORD, txc: 8'h01};
    localparam xgmii_word_t ERROR_XFER = '{txd: ERROR_WORD, txc: 8'hFF};
    localparam xgmii_word_t TERM_XFER  = '{txd: TERM_WORD,  txc: 8'hFF};

    tx_state_e         state_q, state_d;
    xgmii_word_t       out_q, out_d;
    logic              underrun_q, underrun_d;
    logic              done_q, done_d;
    logic              first_q, first_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [IFG_W-1:0]  ifg_q, ifg_d;
    logic              ren_c;

    logic              head_sop;
    logic              head_eop;
    logic [2:0]        head_nbytes;
    logic [XGMII_DATA_W-1:0] enc_txd;
    logic [XGMII_CTRL_W-1:0] enc_txc;
    logic              unused_status;

    assign head_sop      = txhfifo_rstatus[TXSTATUS_SOP];
    assign head_eop      = txhfifo_rstatus[TXSTATUS_EOP];
    assign head_nbytes   = txhfifo_rstatus[TXSTATUS_NBYTES_MSB:TXSTATUS_NBYTES_LSB];
    assign unused_status = ^txhfifo_rstatus[5:3];

    tx_xgmii_term_encode u_term_encode (
        .data_i   (txhfifo_rdata),
        .nbytes_i (head_nbytes),
        .txd_o    (enc_txd),
        .txc_o    (enc_txc)
    );

    // Next-state, next-output and pop decision from the current FIFO head.
    always_comb begin
        state_d    = state_q;
        out_d      = IDLE_XFER;
        underrun_d = 1'b0;
        done_d     = 1'b0;
        first_d    = first_q;
        wait_d     = '0;
        ifg_d      = '0;
        ren_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!txhfifo_rempty) begin
                    if (!head_sop) begin
                        ren_c = 1'b1;
                    end else if (!txhfifo_ralmost_empty ||
                                 wait_q == WAIT_W'(START_WAIT)) begin
                        out_d   = START_XFER;
                        first_d = 1'b1;
                        state_d = ST_DATA;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                first_d = 1'b0;
                if (txhfifo_rempty) begin
                    out_d      = ERROR_XFER;
                    underrun_d = 1'b1;
                    state_d    = ST_DRAIN;
                end else if (head_sop && !first_q) begin
                    // Next frame arrived before this one's EOP: abort without popping it.
                    out_d      = ERROR_XFER;
                    underrun_d = 1'b1;
                    state_d    = ST_IFG;
                end else begin
                    ren_c = 1'b1;
                    out_d = '{txd: txhfifo_rdata, txc: 8'h00};
                    if (head_eop) begin
                        if (head_nbytes == 3'd0) begin
                            state_d = ST_TERM;
                        end else begin
                            out_d   = '{txd: enc_txd, txc: enc_txc};
                            done_d  = 1'b1;
                            state_d = ST_IFG;
                        end
                    end
                end
            end

            ST_TERM: begin
                out_d   = TERM_XFER;
                done_d  = 1'b1;
                state_d = ST_IFG;
            end

            ST_DRAIN: begin
                if (!txhfifo_rempty) begin
                    if (head_eop) begin
                        ren_c   = 1'b1;
                        state_d = ST_IFG;
                    end else if (head_sop) begin
                        state_d = ST_IFG;
                    end else begin
                        ren_c = 1'b1;
                    end
                end
            end

            ST_IFG: begin
                if (ifg_q == IFG_W'(IFG_WORDS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A pop must never be issued while the block is being reset.
    assign txhfifo_ren = ren_c & ~reset_xgmii_tx;

    // State and output word register, updated together.
    always_ff @(posedge clk_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            state_q    <= ST_IDLE;
            out_q      <= IDLE_XFER;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
            first_q    <= 1'b0;
            wait_q     <= '0;
            ifg_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
            first_q    <= first_d;
            wait_q     <= wait_d;
            ifg_q      <= ifg_d;
        end
    end

    assign xgmii_txd     = out_q.txd;
    assign xgmii_txc     = out_q.txc;
    assign tx_underrun   = underrun_q;
    assign tx_frame_done = done_q;

endmodule

// File: tb/tb_tx_xgmii_framer.sv
// Directed bench: FIFO model feeding the framer, expected XGMII words queued
// when frames are loaded and compared cycle by cycle as the DUT emits them.
module tb_tx_xgmii_framer;

    typedef struct packed {
        logic [7:0]  st;
        logic [63:0] d;
    } fw_t;

    typedef struct packed {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        un;
        logic        dn;
    } exp_t;

    localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
    localparam logic [63:0] W_START = 64'hD5555555555555FB;
    localparam logic [63:0] W_ERR   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] W_TERM  = 64'h07070707070707FD;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rdata;
    logic [7:0]  rstatus;
    logic        rempty;
    logic        ralmost_empty;
    logic        ren;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        underrun;
    logic        frame_done;

    fw_t  fifo[$];
    exp_t exq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tx_xgmii_framer dut (
        .clk_xgmii_tx          (clk),
        .reset_xgmii_tx        (rst),
        .txhfifo_rdata         (rdata),
        .txhfifo_rstatus       (rstatus),
        .txhfifo_rempty        (rempty),
        .txhfifo_ralmost_empty (ralmost_empty),
        .txhfifo_ren           (ren),
        .xgmii_txd             (txd),
        .xgmii_txc             (txc),
        .tx_underrun           (underrun),
        .tx_frame_done         (frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
        end
    endtask

    // FIFO head model: first-word-fall-through, almost empty at 2 words or fewer.
    task automatic drive_head();
        if (fifo.size() > 0) begin
            rdata   = fifo[0].d;
            rstatus = fifo[0].st;
            rempty  = 1'b0;
        end else begin
            rdata   = '0;
            rstatus = '0;
            rempty  = 1'b1;
        end
        ralmost_empty = (fifo.size() <= 2);
    endtask

    task automatic push_word(input logic [7:0] st, input logic [63:0] d);
        fifo.push_back('{st: st, d: d});
    endtask

    task automatic expect_word(input logic [63:0] d, input logic [7:0] c,
                               input logic un, input logic dn);
        exq.push_back('{txd: d, txc: c, un: un, dn: dn});
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) expect_word(W_IDLE, 8'hFF, 1'b0, 1'b0);
    endtask

    // Push a run of data words (optionally SOP first), each expected as plain data.
    task automatic load_data(input int nw, input logic [63:0] seed, input bit sop);
        for (int i = 0; i < nw; i++) begin
            logic [63:0] d;
            d = seed + 64'(i) * 64'h0001_0001_0001_0001;
            push_word((sop && i == 0) ? 8'h80 : 8'h00, d);
            expect_word(d, 8'h00, 1'b0, 1'b0);
        end
    endtask

    // One clock: sample pop before the edge, apply it after, then compare outputs.
    task automatic tick();
        logic r;
        exp_t e;
        @(negedge clk);
        r = ren;
        @(posedge clk);
        #1;
        chk("pop_on_empty", 64'(r && fifo.size() == 0), 64'd0);
        if (r && fifo.size() > 0) void'(fifo.pop_front());
        drive_head();
        if (exq.size() > 0) e = exq.pop_front();
        else e = '{txd: W_IDLE, txc: 8'hFF, un: 1'b0, dn: 1'b0};
        chk("txd", txd, e.txd);
        chk("txc", 64'(txc), 64'(e.txc));
        chk("pulses", {62'd0, underrun, frame_done}, {62'd0, e.un, e.dn});
    endtask

    task automatic run_exp();
        int budget = 200;
        while (exq.size() > 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("exp_drained", 64'(exq.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive_head();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_txd", txd, W_IDLE);
        chk("rst_txc", 64'(txc), 64'hFF);
        chk("rst_pulses", {62'd0, underrun, frame_done}, 64'd0);
        chk("rst_ren", 64'(ren), 64'd0);
        rst = 1'b0;
        repeat (3) tick();

        // 64-byte frame, EOP with 8 valid bytes.
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        load_data(7, 64'h1000_2000_3000_4000, 1'b1);
        push_word(8'h40, 64'hCAFE_0000_BEEF_0008);
        expect_word(64'hCAFE_0000_BEEF_0008, 8'h00, 1'b0, 1'b0);
        expect_word(W_TERM, 8'hFF, 1'b0, 1'b1);
        expect_idle(2);
        drive_head();
        run_exp();
        repeat (2) tick();

        // Non-SOP garbage dropped while idle, then a normal frame.
        push_word(8'h38, 64'hDEAD_DEAD_DEAD_0001);
        push_word(8'h00, 64'hDEAD_DEAD_DEAD_0002);
        push_word(8'h40, 64'hDEAD_DEAD_DEAD_0003);
        expect_idle(3);
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        load_data(2, 64'h2222_0000_0000_0000, 1'b1);
        push_word(8'h40, 64'h2222_0000_0000_00FF);
        expect_word(64'h2222_0000_0000_00FF, 8'h00, 1'b0, 1'b0);
        expect_word(W_TERM, 8'hFF, 1'b0, 1'b1);
        expect_idle(2);
        drive_head();
        run_exp();
        chk("garbage_popped", 64'(fifo.size()), 64'd0);

        // Next SOP before EOP: error word, no pop, IFG, then the new frame.
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        load_data(2, 64'h3333_0000_0000_0000, 1'b1);
        expect_word(W_ERR, 8'hFF, 1'b1, 1'b0);
        expect_idle(2);
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        load_data(2, 64'h4444_0000_0000_0000, 1'b1);
        push_word(8'h40, 64'h4444_0000_0000_0EEE);
        expect_word(64'h4444_0000_0000_0EEE, 8'h00, 1'b0, 1'b0);
        expect_word(W_TERM, 8'hFF, 1'b0, 1'b1);
        expect_idle(2);
        drive_head();
        run_exp();

        // Underrun after the 3rd data word, then drain to EOP and frame n=3.
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        load_data(3, 64'h5555_0000_0000_0000, 1'b1);
        expect_word(W_ERR, 8'hFF, 1'b1, 1'b0);
        drive_head();
        run_exp();
        repeat (3) tick();
        push_word(8'h00, 64'h5555_0000_0000_0004);
        push_word(8'h00, 64'h5555_0000_0000_0005);
        push_word(8'h41, 64'h5555_0000_0000_0006);
        expect_idle(5);
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        load_data(3, 64'h6666_0000_0000_0000, 1'b1);
        push_word(8'h7B, 64'h1122334455667788);
        expect_word(64'h07070707FD667788, 8'hF8, 1'b0, 1'b1);
        expect_idle(2);
        drive_head();
        run_exp();
        chk("drain_empty", 64'(fifo.size()), 64'd0);

        // Single-word frame (n=2), then a 2-word frame held almost-empty.
        push_word(8'hC2, 64'hA1A2A3A4A5A6A7A8);
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        expect_word(64'h0707070707FDA7A8, 8'hFC, 1'b0, 1'b1);
        expect_idle(2);
        // Wait counter reaches 16 on the 17th head cycle; start shows one edge later.
        expect_idle(16);
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        load_data(1, 64'h7777_0000_0000_0000, 1'b1);
        push_word(8'h40, 64'h7777_0000_0000_0002);
        expect_word(64'h7777_0000_0000_0002, 8'h00, 1'b0, 1'b0);
        expect_word(W_TERM, 8'hFF, 1'b0, 1'b1);
        expect_idle(2);
        drive_head();
        run_exp();

        // Reset in the middle of DATA.
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        load_data(5, 64'h8888_0000_0000_0000, 1'b1);
        drive_head();
        repeat (3) tick();
        exq.delete();
        rst = 1'b1;
        #1;
        chk("rst_mid_ren", 64'(ren), 64'd0);
        tick();
        fifo.delete();
        drive_head();
        rst = 1'b0;
        repeat (2) tick();
        expect_word(W_START, 8'h01, 1'b0, 1'b0);
        load_data(2, 64'h9999_0000_0000_0000, 1'b1);
        push_word(8'h47, 64'hB1B2B3B4B5B6B7B8);
        expect_word(64'hFDB2B3B4B5B6B7B8, 8'h80, 1'b0, 1'b1);
        expect_idle(2);
        drive_head();
        run_exp();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
